// File: rtl/word_arith_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : word_arith_seq_if
// Description : Command/result handshake bundle for word_arith_seq.
//               Command channel : in_valid/in_ready, in_op, in_a, in_b, in_tag
//               Result channel  : out_valid/out_ready, out_res, out_err, out_tag
//               slave  = the arithmetic unit, master = producer/consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface word_arith_seq_if #(
  parameter int W  = 8,
  parameter int CW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [CW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_res;
  logic          out_err;
  logic [CW-1:0] out_tag;

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_err, out_tag
  );

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_err, out_tag
  );
endinterface
`default_nettype wire

// File: rtl/word_arith_seq.sv
`default_nettype none
// ============================================================================
// Module      : word_arith_seq
// Description : Handshaked W-bit unsigned arithmetic unit. One op per
//               transaction: ADD, SUB, MUL (1 cycle), DIV, MOD, POW (W+1
//               cycles, iterative). Results are modulo 2**W.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - word_arith_seq_if.slave (command + result channels)
// Revision    : 1.0 - initial release
// ============================================================================
module word_arith_seq #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  wire                  clk,
  input  wire                  rst_n,
  word_arith_seq_if.slave      bus
);

  localparam int CNTW = $clog2(W);

  localparam logic [2:0] c_OP_ADD = 3'd0;
  localparam logic [2:0] c_OP_SUB = 3'd1;
  localparam logic [2:0] c_OP_MUL = 3'd2;
  localparam logic [2:0] c_OP_DIV = 3'd3;
  localparam logic [2:0] c_OP_MOD = 3'd4;
  localparam logic [2:0] c_OP_POW = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_POWER  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        r_state;
  logic [2:0]    r_op;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [CW-1:0] r_tag;
  logic [CNTW-1:0] r_cnt;

  // Divider: r_quo starts as the dividend and shifts quotient bits in from
  // the right while dividend bits leave from the left.
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_rem;

  // Power: accumulator, running base square, exponent shifted right.
  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_base;
  logic [W-1:0]  r_exp;

  logic          r_in_ready;
  logic          r_out_valid;
  logic [W-1:0]  r_out_res;
  logic          r_out_err;
  logic [CW-1:0] r_out_tag;

  // One restoring-division step on a W+1-bit shifted partial remainder.
  logic [W:0]    w_rem_sh;
  logic          w_ge;
  logic [W-1:0]  w_diff;
  // Truncated products: only the low W bits are ever needed.
  logic [W-1:0]  w_mul;
  logic [W-1:0]  w_acc_mul;
  logic [W-1:0]  w_base_sq;
  logic [W-1:0]  w_res;
  logic          w_err;

  assign w_rem_sh  = {r_rem, r_quo[W-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_b});
  // When w_ge holds the true difference is below r_b, so W bits suffice.
  assign w_diff    = w_rem_sh[W-1:0] - r_b;
  assign w_mul     = r_a * r_b;
  assign w_acc_mul = r_acc * r_base;
  assign w_base_sq = r_base * r_base;

  // b==0 needs no special datapath: every trial subtract succeeds, giving an
  // all-ones quotient and a remainder equal to the dividend.
  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    case (r_op)
      c_OP_ADD: w_res = r_a + r_b;
      c_OP_SUB: w_res = r_a - r_b;
      c_OP_MUL: w_res = w_mul;
      c_OP_DIV: begin
        w_res = r_quo;
        w_err = (r_b == '0);
      end
      c_OP_MOD: begin
        w_res = r_rem;
        w_err = (r_b == '0);
      end
      c_OP_POW: w_res = r_acc;
      default: begin
        w_res = '0;
        w_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_tag       <= '0;
      r_cnt       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_acc       <= '0;
      r_base      <= '0;
      r_exp       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_res   <= '0;
      r_out_err   <= 1'b0;
      r_out_tag   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_op       <= bus.in_op;
            r_a        <= bus.in_a;
            r_b        <= bus.in_b;
            r_tag      <= bus.in_tag;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            case (bus.in_op)
              c_OP_DIV, c_OP_MOD: begin
                r_quo   <= bus.in_a;
                r_rem   <= '0;
                r_state <= S_DIVIDE;
              end
              c_OP_POW: begin
                r_acc   <= W'(1);
                r_base  <= bus.in_a;
                r_exp   <= bus.in_b;
                r_state <= S_POWER;
              end
              default: r_state <= S_DONE;
            endcase
          end
        end

        S_DIVIDE: begin
          r_rem <= w_ge ? w_diff : w_rem_sh[W-1:0];
          r_quo <= {r_quo[W-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNTW'(W-1)) r_state <= S_DONE;
        end

        S_POWER: begin
          if (r_exp[0]) r_acc <= w_acc_mul;
          r_base <= w_base_sq;
          r_exp  <= r_exp >> 1;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CNTW'(W-1)) r_state <= S_DONE;
        end

        S_DONE: begin
          // First DONE cycle captures the result; later cycles wait for
          // the consumer with outputs frozen.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_res   <= w_res;
            r_out_err   <= w_err;
            r_out_tag   <= r_tag;
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_res   = r_out_res;
  assign bus.out_err   = r_out_err;
  assign bus.out_tag   = r_out_tag;

endmodule
`default_nettype wire
